mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle ARM-subset control FSM: sequences fetch/decode/execute/memory
// steps, keeps its own NZCV register and gates all writes on the condition code.
module mc_ctrl_fsm #(
  parameter int WAIT_EN = 1,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  input  logic               MemReady,
  input  logic               Halt,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         ALUControl,
  output logic [STATE_W-1:0] state,
  output logic               Halted
);

  // state  | meaning
  // FETCH  | read instruction, PC+4; parks here while Halt
  // DECODE | read registers, pick instruction class
  // MEMADR | compute load/store address
  // MEMRD  | load data read, waits for MemReady
  // MEMWB  | write loaded data to Rd
  // MEMWR  | store data write, waits for MemReady
  // EXECR  | ALU op with register operand
  // EXECI  | ALU op with immediate operand
  // ALUWB  | write ALU result to Rd
  // BRANCH | conditional PC update
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t      cur_st, nxt_st;
  logic [3:0]  nzcv;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        rd_pc;
  logic        mem_rdy;
  logic        fetch_go;
  logic        cond_ex;
  logic [1:0]  alu_dec;
  logic        is_arith;
  logic        pc_w, mem_w, reg_w, ir_w;
  logic        unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd_pc     = (Instr[3:0] == 4'hF);
  assign unused_rn = ^Instr[7:4];

  assign mem_rdy  = (WAIT_EN != 0) ? MemReady : 1'b1;
  assign fetch_go = mem_rdy & ~Halt;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = nzcv[2];
      4'b0001: cond_ex = ~nzcv[2];
      4'b0010: cond_ex = nzcv[1];
      4'b0011: cond_ex = ~nzcv[1];
      4'b0100: cond_ex = nzcv[3];
      4'b0101: cond_ex = ~nzcv[3];
      4'b0110: cond_ex = nzcv[0];
      4'b0111: cond_ex = ~nzcv[0];
      4'b1000: cond_ex = nzcv[1] & ~nzcv[2];
      4'b1001: cond_ex = ~nzcv[1] | nzcv[2];
      4'b1010: cond_ex = (nzcv[3] == nzcv[0]);
      4'b1011: cond_ex = (nzcv[3] != nzcv[0]);
      4'b1100: cond_ex = ~nzcv[2] & (nzcv[3] == nzcv[0]);
      4'b1101: cond_ex = nzcv[2] | (nzcv[3] != nzcv[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    alu_dec  = 2'b00;
    is_arith = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_dec = 2'b00; is_arith = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; is_arith = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: alu_dec = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_st <= FETCH;
    else        cur_st <= nxt_st;
  end

  // Flags are written at the end of execute, so the condition seen this cycle is pre-update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nzcv <= 4'b0000;
    end else if ((cur_st == EXECR || cur_st == EXECI) && cond_ex && funct[0]) begin
      nzcv[3:2] <= ALUFlags[3:2];
      if (is_arith) nzcv[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    nxt_st     = cur_st;
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ir_w       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (cur_st)
      FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (fetch_go) begin
          ir_w   = 1'b1;
          pc_w   = 1'b1;
          nxt_st = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   nxt_st = funct[5] ? EXECI : EXECR;
          2'b01:   nxt_st = MEMADR;
          2'b10:   nxt_st = BRANCH;
          default: nxt_st = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        nxt_st  = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_rdy) nxt_st = MEMWB;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = cond_ex;
        if (mem_rdy) nxt_st = FETCH;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = cond_ex;
        pc_w      = cond_ex & rd_pc;
        nxt_st    = FETCH;
      end
      EXECR: begin
        ALUControl = alu_dec;
        nxt_st     = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        nxt_st     = ALUWB;
      end
      ALUWB: begin
        reg_w  = cond_ex;
        pc_w   = cond_ex & rd_pc;
        nxt_st = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_w      = cond_ex;
        nxt_st    = FETCH;
      end
      default: nxt_st = FETCH;
    endcase
  end

  // Enables are masked by reset so nothing is written while reset is held low.
  assign PCWrite  = reset & pc_w;
  assign MemWrite = reset & mem_w;
  assign RegWrite = reset & reg_w;
  assign IRWrite  = reset & ir_w;
  assign Halted   = reset & (cur_st == FETCH) & Halt;

  assign ImmSrc = op;
  assign RegSrc = {(op == 2'b01) & ~funct[0], (op == 2'b10)};

  always_comb begin
    state      = '0;
    state[3:0] = cur_st;
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-cycle vector tables checked through a scoreboard
// queue, plus an asynchronous reset dropped in the middle of a store.
module tb_mc_ctrl_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady, Halt;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Halted;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [3:0]  state;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .Halt(Halt), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .state(state), .Halted(Halted)
  );

  always #5 clk = ~clk;

  // expected = {state, PCWrite, MemWrite, RegWrite, IRWrite, Halted, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
  typedef struct {
    logic        rst;
    logic [19:0] instr;
    logic [3:0]  flags;
    logic        mr;
    logic        halt;
    logic [17:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [21:0] exp;
    string       name;
  } sb_t;

  // select tuples {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
  localparam logic [6:0] SF  = 7'b0_01_10_10;
  localparam logic [6:0] SMA = 7'b0_00_01_00;
  localparam logic [6:0] SBR = 7'b0_00_01_10;
  localparam logic [6:0] SXR = 7'b0_00_00_00;
  localparam logic [6:0] SXI = 7'b0_00_01_00;
  localparam logic [6:0] SMM = 7'b1_00_00_00;
  localparam logic [6:0] SWB = 7'b0_00_00_01;
  localparam logic [6:0] SAW = 7'b0_00_00_00;
  // enables {PCWrite, MemWrite, RegWrite, IRWrite}
  localparam logic [3:0] EN0 = 4'b0000;
  localparam logic [3:0] ENF = 4'b1001;
  localparam logic [3:0] ERW = 4'b0010;
  localparam logic [3:0] EMW = 4'b0100;
  localparam logic [3:0] EPC = 4'b1000;
  localparam logic [3:0] EPR = 4'b1010;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  sb_t  sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t v(input logic rst, input logic [19:0] ins, input logic [3:0] fl,
                             input logic mr, input logic hl, input logic [3:0] st,
                             input logic [3:0] en, input logic hlt, input logic [6:0] sel,
                             input logic [1:0] alc, input string nm);
    vec_t r;
    r.rst = rst; r.instr = ins; r.flags = fl; r.mr = mr; r.halt = hl;
    r.exp = {st, en, hlt, sel, alc};
    r.name = nm;
    return r;
  endfunction

  // RegSrc/ImmSrc follow the instruction word only
  function automatic logic [3:0] src_model(input logic [19:0] ins);
    logic [1:0] o;
    o = ins[15:14];
    return {(o == 2'b01) & ~ins[8], (o == 2'b10), o};
  endfunction

  task automatic check_out();
    sb_t         e;
    logic [21:0] got;
    got = {state, PCWrite, MemWrite, RegWrite, IRWrite, Halted, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, RegSrc, ImmSrc};
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty got=%h", got);
    end else begin
      e = sb_q.pop_front();
      if (got === e.exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h", e.name, got, e.exp);
    end
  endtask

  task automatic apply(input vec_t x);
    sb_t e;
    @(posedge clk);
    #1;
    reset = x.rst; Instr = x.instr; ALUFlags = x.flags; MemReady = x.mr; Halt = x.halt;
    e.exp  = {x.exp, src_model(x.instr)};
    e.name = x.name;
    sb_q.push_back(e);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] i;
    reset = 1'b0; Instr = 20'h0; ALUFlags = 4'h0; MemReady = 1'b0; Halt = 1'b0;

    i = 20'hE0821;
    tbl_a.push_back(v(1'b0, i, 4'h0, 1'b1, 1'b0, 4'd0, EN0, 1'b0, SF, 2'd0, "rst_hold"));
    tbl_a.push_back(v(1'b0, i, 4'h0, 1'b1, 1'b1, 4'd0, EN0, 1'b0, SF, 2'd0, "rst_halt"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b0, 1'b0, 4'd0, EN0, 1'b0, SF, 2'd0, "first_wait"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "add_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "add_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd6, EN0, 1'b0, SXR, 2'd0, "add_x"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd8, ERW, 1'b0, SAW, 2'd0, "add_wb"));
    i = 20'hE5921;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "ldr_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "ldr_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd2, EN0, 1'b0, SMA, 2'd0, "ldr_ma"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b0, 1'b0, 4'd3, EN0, 1'b0, SMM, 2'd0, "ldr_rd_wait"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd3, EN0, 1'b0, SMM, 2'd0, "ldr_rd"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd4, ERW, 1'b0, SWB, 2'd0, "ldr_wb"));
    i = 20'hE5821;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "str_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "str_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd2, EN0, 1'b0, SMA, 2'd0, "str_ma"));
    for (int k = 0; k < 3; k++)
      tbl_a.push_back(v(1'b1, i, 4'h0, 1'b0, 1'b0, 4'd5, EMW, 1'b0, SMM, 2'd0, "str_wait"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd5, EMW, 1'b0, SMM, 2'd0, "str_wr"));
    i = 20'hE0521;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "subs_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "subs_d"));
    tbl_a.push_back(v(1'b1, i, 4'h4, 1'b1, 1'b0, 4'd6, EN0, 1'b0, SXR, 2'd1, "subs_x"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd8, ERW, 1'b0, SAW, 2'd0, "subs_wb"));
    i = 20'h0A000;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "beq_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "beq_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd9, EPC, 1'b0, SBR, 2'd0, "beq_taken"));
    i = 20'h1A000;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "bne_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "bne_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd9, EN0, 1'b0, SBR, 2'd0, "bne_not_taken"));
    i = 20'hE0100;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "ands_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "ands_d"));
    tbl_a.push_back(v(1'b1, i, 4'hB, 1'b1, 1'b0, 4'd6, EN0, 1'b0, SXR, 2'd2, "ands_x"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd8, ERW, 1'b0, SAW, 2'd0, "ands_wb"));
    i = 20'h4A000;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "bmi_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "bmi_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd9, EPC, 1'b0, SBR, 2'd0, "bmi_taken"));
    i = 20'h2A000;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "bcs_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "bcs_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd9, EN0, 1'b0, SBR, 2'd0, "bcs_cv_kept"));
    i = 20'hE381F;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "orr_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "orr_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd7, EN0, 1'b0, SXI, 2'd3, "orr_xi"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd8, EPR, 1'b0, SAW, 2'd0, "orr_wb_pc"));
    i = 20'hEC000;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "op3_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "op3_d"));
    i = 20'hE0821;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "hlt_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "hlt_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b1, 4'd6, EN0, 1'b0, SXR, 2'd0, "hlt_x"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b1, 4'd8, ERW, 1'b0, SAW, 2'd0, "hlt_wb"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b1, 4'd0, EN0, 1'b1, SF, 2'd0, "hlt_park0"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b0, 1'b1, 4'd0, EN0, 1'b1, SF, 2'd0, "hlt_park1"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "hlt_resume"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "hlt_resume_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd6, EN0, 1'b0, SXR, 2'd0, "hlt_resume_x"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd8, ERW, 1'b0, SAW, 2'd0, "hlt_resume_wb"));
    i = 20'hE0521;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "subs2_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "subs2_d"));
    tbl_a.push_back(v(1'b1, i, 4'h4, 1'b1, 1'b0, 4'd6, EN0, 1'b0, SXR, 2'd1, "subs2_x"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd8, ERW, 1'b0, SAW, 2'd0, "subs2_wb"));
    i = 20'hE5821;
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "str2_f"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "str2_d"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd2, EN0, 1'b0, SMA, 2'd0, "str2_ma"));
    tbl_a.push_back(v(1'b1, i, 4'h0, 1'b0, 1'b0, 4'd5, EMW, 1'b0, SMM, 2'd0, "str2_wait"));

    // after the mid-store reset Z must be clear again: BEQ falls through, BNE is taken
    i = 20'h0A000;
    tbl_b.push_back(v(1'b0, i, 4'h0, 1'b1, 1'b0, 4'd0, EN0, 1'b0, SF, 2'd0, "rst_mid_hold"));
    tbl_b.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "post_beq_f"));
    tbl_b.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "post_beq_d"));
    tbl_b.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd9, EN0, 1'b0, SBR, 2'd0, "post_beq_flags_clr"));
    i = 20'h1A000;
    tbl_b.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd0, ENF, 1'b0, SF, 2'd0, "post_bne_f"));
    tbl_b.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd1, EN0, 1'b0, SF, 2'd0, "post_bne_d"));
    tbl_b.push_back(v(1'b1, i, 4'h0, 1'b1, 1'b0, 4'd9, EPC, 1'b0, SBR, 2'd0, "post_bne_taken"));

    foreach (tbl_a[k]) apply(tbl_a[k]);

    // reset dropped mid-cycle while the store is still waiting on memory
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if (MemWrite === 1'b0 && state === 4'd0 && PCWrite === 1'b0 && IRWrite === 1'b0)
      n_pass++;
    else
      $display("FAIL rst_async got MemWrite=%b state=%0d PCWrite=%b IRWrite=%b expected 0/0/0/0",
               MemWrite, state, PCWrite, IRWrite);

    foreach (tbl_b[k]) apply(tbl_b[k]);

    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
